pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline controller for the IF / ID / EX core. It sits beside the decoder and drives the hold, flush and PC-redirect controls of the PC, if_id and id_ex stages. It runs a write-back scoreboard that stalls ID on read-after-write hazards, and a small state machine that squashes wrong-path instructions after a taken branch or jump. It also keeps stall and flush performance counters.

## Interface

Parameters:
- `WB_LAT`, default 2: cycles from ID issue to register-file write; legal range 1..4.
- `REDIR_CYC`, default 1: extra cycles of IF/ID squash after a redirect; legal range 1..3.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_oh` in 5: decoder op code (0 = none/illegal, 1 ADDI, 2 ADD, 3 SUB, 4 BNE, 5 BEQ, 6 JAL, 7 LUI).
- `id_rs1_addr` in 5, `id_rs2_addr` in 5: source registers from the decoder.
- `id_rd_addr` in 5, `id_rd_wen` in 1: destination register and its write enable, from the decoder.
- `ex_jump` in 1, `ex_jump_addr` in 32: taken BNE/BEQ or JAL resolved in EX, with its target.
- `stall_req_ext` in 1: external stall request (memory/bus wait).
- `hold_pc` out 1: freeze the PC.
- `hold_if_id` out 1: freeze the if_id register.
- `flush_if_id` out 1: load a bubble into if_id.
- `flush_id_ex` out 1: load a bubble into id_ex.
- `pc_load` out 1, `pc_load_addr` out 32: redirect the PC to `pc_load_addr`.
- `issue` out 1: the ID instruction advances to EX this cycle.
- `stall_cnt` out 32, `flush_cnt` out 32: performance counters.

## Operation

- **Source usage by `id_oh`:**
  - 1 (ADDI) reads rs1 only.
  - 2–5 (ADD, SUB, BNE, BEQ) read rs1 and rs2.
  - 0, 6, 7 read nothing.
  - A source at address x0 never creates a hazard.
- **Scoreboard:** a shift line of `WB_LAT` entries, each {valid, rd}.
  - Every cycle, entry 0 loads {`issue` & `id_rd_wen` & (`id_rd_addr`≠0), `id_rd_addr`}.
  - Every other entry takes the value of its predecessor; the last entry is discarded.
  - `hazard` = `id_valid` and some used source equals the rd of a valid entry.
- **States:**
  - **RUN.**
  - **REDIR**, with a down-counter `rcnt`.
- **RUN priority, high to low:**
  1. `ex_jump`: assert `pc_load`, drive `pc_load_addr` = `ex_jump_addr`, assert `flush_if_id` and `flush_id_ex`. Load `rcnt` = `REDIR_CYC`−1 and go to REDIR.
  2. `stall_req_ext` or `hazard`: assert `hold_pc`, `hold_if_id` and `flush_id_ex`; `issue` = 0.
  3. Otherwise `issue` = `id_valid`; all controls are 0.
- **REDIR:**
  - Each cycle asserts `flush_if_id` and `flush_id_ex`; `issue` = 0.
  - When `rcnt` = 0, go to RUN; otherwise decrement `rcnt`.
  - `ex_jump` in REDIR has the same effect as in RUN: redirect, reload `rcnt`, stay in REDIR.
  - `stall_req_ext` in REDIR is ignored; the flush has priority.
- **In-flight writes on a redirect:** scoreboard entries are never cleared by a redirect, so a JAL in EX still writes rd.
- **Counters:**
  - `stall_cnt` increments once per cycle in which RUN rule 2 applies.
  - `flush_cnt` increments once per `ex_jump` accepted.
  - Both wrap modulo 2^32.
- **Reset:**
  - State goes to RUN, `rcnt` to 0, every scoreboard entry to invalid, both counters to 0.
  - While `rst` is high, all combinational outputs are forced to 0 (`pc_load_addr` = 0), regardless of other inputs.

## Timing

- All control outputs are combinational from the current inputs and state, with zero latency. The state, scoreboard and counters update on the `clk` rising edge.
- **Write-back timing:** an instruction issued in cycle t writes rd at the end of cycle t+`WB_LAT`. A dependent instruction held in ID stalls for cycles t+1 … t+`WB_LAT` and issues in t+`WB_LAT`+1.
- **Redirect timing:** with `ex_jump` in cycle t, the PC fetches the target in t+1. if_id and id_ex are squashed in t … t+`REDIR_CYC`. The first target-path instruction may issue in t+`REDIR_CYC`+1.
- **Simultaneous events:**
  - `ex_jump` with a hazard: the jump wins and `stall_cnt` does not increment.
  - `ex_jump` with `stall_req_ext`: the jump wins.
- **Reset mid-operation:** reset during REDIR or during a stall returns to RUN with an empty scoreboard on the next cycle.

## Structure

- Package `pipe_ctrl_pkg` holds:
  - the op codes `OH_NONE` through `OH_LUI` (0–7), shared with the decoder and EX;
  - the state encoding `ST_RUN` / `ST_REDIR`.
- Sub-module `wb_scoreboard`:
  - parameter `WB_LAT`;
  - inputs: the push interface and rs1/rs2 with their use flags;
  - output: `hazard`.
- The top level keeps the FSM, the counters and the output muxing.

## Test plan

1. **Back-to-back dependency, `WB_LAT`=2:** ADD x1,x2,x3 then ADD x4,x1,x5.
   - Required: `hold_pc`/`hold_if_id`/`flush_id_ex` high for 2 cycles, then `issue`=1, then `stall_cnt`=2.
2. **x0 and unused-source cases:**
   - ADDI x0 followed by ADD x6,x0,x0: no stall.
   - LUI x1 followed by JAL: no stall.
3. **Taken BEQ, `ex_jump_addr`=0x0000_0040, `REDIR_CYC`=1:**
   - Required: `pc_load`=1 with addr 0x40 for 1 cycle; `flush_if_id`/`flush_id_ex` high for 2 cycles; `flush_cnt`=1; issue resumes in cycle 3.
4. **`ex_jump` together with `stall_req_ext` and a hazard:**
   - Required: jump outputs only, `stall_cnt` unchanged.
   - A second `ex_jump` during REDIR reloads the PC and extends the squash.
5. **`rst` asserted while in REDIR with 2 valid scoreboard entries:**
   - Required: all outputs 0 during reset; after reset, a dependent ADD issues without stalling; counters read 0.
6. **Counter wrap:** preload via force to `stall_cnt`=0xFFFF_FFFF, one stall cycle -> 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared op codes, FSM encoding and scoreboard entry type for the IF/ID/EX
// pipeline controller.
package pipe_ctrl_pkg;
  localparam logic [4:0] OH_NONE = 5'd0;
  localparam logic [4:0] OH_ADDI = 5'd1;
  localparam logic [4:0] OH_ADD  = 5'd2;
  localparam logic [4:0] OH_SUB  = 5'd3;
  localparam logic [4:0] OH_BNE  = 5'd4;
  localparam logic [4:0] OH_BEQ  = 5'd5;
  localparam logic [4:0] OH_JAL  = 5'd6;
  localparam logic [4:0] OH_LUI  = 5'd7;

  typedef enum logic {ST_RUN = 1'b0, ST_REDIR = 1'b1} state_e;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
  } sb_ent_t;

  function automatic logic uses_rs1(input logic [4:0] oh);
    case (oh)
      OH_ADDI, OH_ADD, OH_SUB, OH_BNE, OH_BEQ: uses_rs1 = 1'b1;
      OH_NONE, OH_JAL, OH_LUI:                 uses_rs1 = 1'b0;
      default:                                 uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [4:0] oh);
    case (oh)
      OH_ADD, OH_SUB, OH_BNE, OH_BEQ: uses_rs2 = 1'b1;
      default:                        uses_rs2 = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/wb_scoreboard.sv
// Write-back shift line: tracks destination registers of issued instructions
// until they reach the register file and flags RAW hazards in ID.
module wb_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int WB_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_vld,
  input  logic [4:0] push_rd,
  input  logic [4:0] rs1_addr,
  input  logic       rs1_use,
  input  logic [4:0] rs2_addr,
  input  logic       rs2_use,
  output logic       hazard
);
  sb_ent_t [WB_LAT-1:0] ent_q, ent_d;
  logic    [WB_LAT-1:0] hit;

  always_comb begin
    ent_d    = ent_q;
    ent_d[0] = '{vld: push_vld, rd: push_rd};
    for (int i = 1; i < WB_LAT; i++) ent_d[i] = ent_q[i-1];
  end

  // x0 is hardwired, so a read of it can never depend on an in-flight write.
  for (genvar i = 0; i < WB_LAT; i++) begin : g_hit
    assign hit[i] = ent_q[i].vld &&
                    ((rs1_use && (rs1_addr != 5'd0) && (rs1_addr == ent_q[i].rd)) ||
                     (rs2_use && (rs2_addr != 5'd0) && (rs2_addr == ent_q[i].rd)));
  end

  assign hazard = |hit;

  always_ff @(posedge clk) begin
    if (rst) ent_q <= '0;
    else     ent_q <= ent_d;
  end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: RAW stall via write-back scoreboard, redirect/squash FSM
// and stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WB_LAT    = 2,
  parameter int REDIR_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_oh,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_rd_wen,
  input  logic        ex_jump,
  input  logic [31:0] ex_jump_addr,
  input  logic        stall_req_ext,
  output logic        hold_pc,
  output logic        hold_if_id,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        pc_load,
  output logic [31:0] pc_load_addr,
  output logic        issue,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);
  state_e      state_q, state_d;
  logic [1:0]  rcnt_q, rcnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic        hazard;

  wb_scoreboard #(.WB_LAT(WB_LAT)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .push_vld (issue & id_rd_wen & (id_rd_addr != 5'd0)),
    .push_rd  (id_rd_addr),
    .rs1_addr (id_rs1_addr),
    .rs1_use  (id_valid & uses_rs1(id_oh)),
    .rs2_addr (id_rs2_addr),
    .rs2_use  (id_valid & uses_rs2(id_oh)),
    .hazard   (hazard)
  );

  always_comb begin
    hold_pc      = 1'b0;
    hold_if_id   = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    pc_load      = 1'b0;
    pc_load_addr = '0;
    issue        = 1'b0;
    state_d      = state_q;
    rcnt_d       = rcnt_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (!rst) begin
      // A redirect wins over everything, in either state.
      if (ex_jump) begin
        pc_load      = 1'b1;
        pc_load_addr = ex_jump_addr;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        rcnt_d       = 2'(REDIR_CYC - 1);
        state_d      = ST_REDIR;
        flush_cnt_d  = flush_cnt_q + 32'd1;
      end else if (state_q == ST_REDIR) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        if (rcnt_q == 2'd0) state_d = ST_RUN;
        else                rcnt_d  = rcnt_q - 2'd1;
      end else if (stall_req_ext || hazard) begin
        hold_pc     = 1'b1;
        hold_if_id  = 1'b1;
        flush_id_ex = 1'b1;
        stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
        issue = id_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      rcnt_q      <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule
